// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-write initiator: frame layout, FSM state
// encoding and the register address map of the SPI register peripheral.
package spi_ctrl_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RW_BIT  = 15;

    // Register map shared with the peripheral.
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftHi,
        StShiftLo,
        StHold,
        StGap
    } spi_state_e;

    // Frame is {rw, addr, data}, sent MSB first.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic              rw,
                                                      input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request handshake between a register-programming client and spi_controller.
// The controller takes the slave modport, the client the master modport.
interface spi_controller_if;
    import spi_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              done;
    logic              busy;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready, done, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready, done, busy
    );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period tick generator. Counts 0..CLK_DIV-1 and flags the terminal count
// (tick_o) and the cycle before it (pre_tick_o). clr_i restarts the count from 0.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam logic [7:0] TermCnt = 8'(CLK_DIV - 1);
    localparam logic [7:0] PreCnt  = 8'(CLK_DIV - 2);

    logic [7:0] cnt_q, cnt_d;

    // Next count: restart on clear, otherwise increment.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i) begin
            cnt_d = 8'd0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o     = (cnt_q == TermCnt);
    assign pre_tick_o = (cnt_q == PreCnt);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one 16-bit {rw, addr, data} frame per accepted request, MSB
// first, each FSM state lasting CLK_DIV clk cycles. Optional read-back of bits 7..0 on
// CIPO is enabled by defining SPI_CONTROLLER_READ_EN.
module spi_controller
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_controller_if.slave   req,
    output logic              nCS,
    output logic              SCLK,
    output logic              COPI
`ifdef SPI_CONTROLLER_READ_EN
    ,
    input  logic              CIPO,
    output logic [DATA_W-1:0] rd_data
`endif
);

    spi_state_e         state_q;
    logic [FRAME_W-1:0] shreg_q;
    logic [3:0]         bit_cnt_q;
    logic               ncs_q;
    logic               sclk_q;
    logic               done_q;
    logic               busy_q;
    logic               ready_q;

    logic tick;
    logic pre_tick;
    logic div_clr;
    logic accept;

`ifdef SPI_CONTROLLER_READ_EN
    logic              rw_q;
    logic [DATA_W-1:0] rd_shift_q;
    logic [DATA_W-1:0] rd_data_q;
`endif

    assign accept  = req.req_valid & ready_q;
    // Every state exits on tick, so clearing on tick restarts the count on each entry.
    assign div_clr = (state_q == StIdle) | tick;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (div_clr),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    // Frame FSM; all pin and handshake outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= 4'd0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
            rw_q       <= 1'b0;
            rd_shift_q <= '0;
            rd_data_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q   <= StSetup;
                        shreg_q   <= pack_frame(req.req_rw, req.req_addr, req.req_data);
                        bit_cnt_q <= 4'd0;
                        ncs_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
                        rw_q      <= req.req_rw;
`endif
                    end
                end
                StSetup: begin
                    if (tick) begin
                        state_q <= StShiftHi;
                        sclk_q  <= 1'b1;
                    end
                end
                StShiftHi: begin
                    if (tick) begin
                        state_q <= StShiftLo;
                        sclk_q  <= 1'b0;
                        // COPI is shreg_q MSB, so the shift presents the next bit.
                        if (bit_cnt_q != 4'd15) begin
                            shreg_q <= shreg_q << 1;
                        end
                    end
                end
                StShiftLo: begin
                    if (tick) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            state_q <= StHold;
                        end else begin
                            state_q <= StShiftHi;
                            sclk_q  <= 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
                            // Entering SHIFT_HI for frame bits 7..0 (bit_cnt 8..15).
                            if (!rw_q && bit_cnt_q >= 4'd7) begin
                                rd_shift_q <= {rd_shift_q[DATA_W-2:0], CIPO};
                            end
`endif
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        state_q <= StGap;
                        ncs_q   <= 1'b1;
                        shreg_q <= '0;
                    end
                end
                StGap: begin
                    // done lands in the final GAP cycle.
                    if (pre_tick) begin
                        done_q <= 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
                        if (!rw_q) begin
                            rd_data_q <= rd_shift_q;
                        end
`endif
                    end
                    if (tick) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign nCS           = ncs_q;
    assign SCLK          = sclk_q;
    assign COPI          = shreg_q[RW_BIT];
    assign req.req_ready = ready_q;
    assign req.busy      = busy_q;
    assign req.done      = done_q;
`ifdef SPI_CONTROLLER_READ_EN
    assign rd_data       = rd_data_q;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller (CLK_DIV=4). Expected frames are queued at
// request time and compared against frames decoded from SCLK/COPI when done pulses.
// Read-back tests are included when SPI_CONTROLLER_READ_EN is defined.
module tb_spi_controller;
    import spi_ctrl_pkg::*;

    localparam int Div = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic nCS, SCLK, COPI;

    always #5 clk = ~clk;

    spi_controller_if bus ();

`ifdef SPI_CONTROLLER_READ_EN
    logic              CIPO;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        rd_pat = 8'h00;
`endif

    spi_controller #(
        .CLK_DIV (Div)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus),
        .nCS   (nCS),
        .SCLK  (SCLK),
        .COPI  (COPI)
`ifdef SPI_CONTROLLER_READ_EN
        ,
        .CIPO    (CIPO),
        .rd_data (rd_data)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  regs[128];

    // Bench-side SPI decoder.
    logic [15:0] mon_sh = 16'h0;
    int          mon_edges = 0;
    logic [15:0] last_frame = 16'h0;
    int          last_edges = 0;

    always @(negedge nCS) begin
        mon_sh    = 16'h0;
        mon_edges = 0;
    end

    always @(posedge SCLK) begin
        mon_sh    = {mon_sh[14:0], COPI};
        mon_edges = mon_edges + 1;
    end

    always @(posedge nCS) begin
        last_frame = mon_sh;
        last_edges = mon_edges;
    end

`ifdef SPI_CONTROLLER_READ_EN
    // Peripheral answer: bits 7..0 of rd_pat, ready before the rising edge that samples them.
    always_comb begin
        CIPO = 1'b0;
        if (!nCS && mon_edges >= 8 && mon_edges <= 15) begin
            CIPO = rd_pat[3'(15 - mon_edges)];
        end
    end
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at the negedge of T+35*Div+1.
    task automatic do_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                            input bit hold, input logic [6:0] na, input logic [7:0] nd,
                            input bit poke);
        int ncs_low, first_low, last_low, done_cnt, done_at, ready_at, tail_high;
        logic [15:0] exp;
        check_eq("ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = a;
        bus.req_data  = d;
        exp_q.push_back({rw, a, d});
        ncs_low = 0; first_low = -1; last_low = -1; done_cnt = 0;
        done_at = -1; ready_at = -1; tail_high = 0;
        for (int i = 1; i <= 35 * Div + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check_eq("ready_drop", 32'(bus.req_ready), 32'd0);
                check_eq("busy_set", 32'(bus.busy), 32'd1);
                if (hold) begin
                    bus.req_addr = na;
                    bus.req_data = nd;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (poke && i == 20) begin
                bus.req_valid = 1'b1;
                bus.req_rw    = ~rw;
                bus.req_addr  = ~a;
                bus.req_data  = ~d;
            end
            if (poke && i == 24) bus.req_valid = 1'b0;
            if (!nCS) begin
                ncs_low++;
                if (first_low < 0) first_low = i;
                last_low = i;
            end else if (first_low >= 0) begin
                tail_high++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp = exp_q.pop_front();
                        check_eq("frame", 32'(last_frame), 32'(exp));
                    end
                    check_eq("sclk_edges", 32'(last_edges), 32'd16);
                    if (last_frame[15]) regs[last_frame[14:8]] = last_frame[7:0];
                end
            end
            if (bus.req_ready && ready_at < 0) ready_at = i;
        end
        check_eq("ncs_low_cycles", 32'(ncs_low), 32'(34 * Div));
        check_eq("ncs_first_low", 32'(first_low), 32'd1);
        check_eq("ncs_last_low", 32'(last_low), 32'(34 * Div));
        check_eq("done_at", 32'(done_at), 32'(35 * Div));
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("ready_at", 32'(ready_at), 32'(35 * Div + 1));
        check_eq("ncs_gap", 32'(tail_high), 32'(Div + 1));
    endtask

    initial begin
        int waited;
        int cnt;
        for (int r = 0; r < 128; r++) regs[r] = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 7'h00;
        bus.req_data  = 8'h00;

        // Reset values while rst_n is held low.
        #23;
        check_eq("rst_ncs", 32'(nCS), 32'd1);
        check_eq("rst_sclk", 32'(SCLK), 32'd0);
        check_eq("rst_copi", 32'(COPI), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Single write 0x00 <- 0xF0.
        do_frame(1'b1, ADDR_EN_OUT_7_0, 8'hF0, 1'b0, 7'h00, 8'h00, 1'b0);

        // Back-to-back programming with req_valid held high.
        do_frame(1'b1, ADDR_PWM_DUTY, 8'h80, 1'b1, ADDR_EN_PWM_7_0, 8'hFF, 1'b0);
        do_frame(1'b1, ADDR_EN_PWM_7_0, 8'hFF, 1'b0, 7'h00, 8'h00, 1'b0);
        check_eq("reg_pwm_duty", 32'(regs[ADDR_PWM_DUTY]), 32'h80);
        check_eq("reg_en_pwm_7_0", 32'(regs[ADDR_EN_PWM_7_0]), 32'hFF);

        // Request poked while busy must not disturb the frame or start another.
        do_frame(1'b1, ADDR_EN_PWM_15_8, 8'h5A, 1'b0, 7'h00, 8'h00, 1'b1);
        cnt = 0;
        for (int i = 0; i < 3 * Div; i++) begin
            @(negedge clk);
            if (!nCS || bus.done) cnt++;
        end
        check_eq("no_extra_frame", 32'(cnt), 32'd0);

        // Reset after the 7th rising SCLK edge.
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = ADDR_EN_PWM_15_8;
        bus.req_data  = 8'h3C;
        @(negedge clk);
        bus.req_valid = 1'b0;
        waited = 0;
        while (mon_edges < 7 && waited < 40 * Div) begin
            @(negedge clk);
            waited++;
        end
        check_eq("mid_edges", 32'(mon_edges), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_ncs", 32'(nCS), 32'd1);
        check_eq("async_sclk", 32'(SCLK), 32'd0);
        check_eq("async_ready", 32'(bus.req_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done || !nCS) cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * Div; i++) begin
            @(negedge clk);
            if (bus.done || !nCS) cnt++;
        end
        check_eq("abort_quiet", 32'(cnt), 32'd0);
        do_frame(1'b1, ADDR_EN_OUT_15_8, 8'h55, 1'b0, 7'h00, 8'h00, 1'b0);
        check_eq("reg_en_out_15_8", 32'(regs[ADDR_EN_OUT_15_8]), 32'h55);

`ifdef SPI_CONTROLLER_READ_EN
        rd_pat = 8'hA5;
        do_frame(1'b0, ADDR_EN_PWM_7_0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0);
        check_eq("rd_data", 32'(rd_data), 32'hA5);
        rd_pat = 8'h3C;
        do_frame(1'b1, ADDR_EN_OUT_7_0, 8'h11, 1'b0, 7'h00, 8'h00, 1'b0);
        check_eq("rd_data_hold", 32'(rd_data), 32'hA5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI initiator that serialises register-write frames onto nCS/SCLK/COPI for the on-chip SPI register peripheral, or for an external one.
- Used as the bring-up and test driver that programs the output-enable, PWM-enable and duty-cycle registers.
- Accepts one write request per valid/ready handshake and emits one 16-bit SPI mode-0 frame, MSB first.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles. Legal range 2..255. Must be at least 4 when driving the synchronised peripheral.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle and able to accept
- req_rw  in  1  frame bit 15; 1 = write
- req_addr  in  7  frame bits 14:8
- req_data  in  8  frame bits 7:0
- done  out  1  one-cycle pulse at end of frame
- busy  out  1  high from accept through end of GAP
- nCS  out  1  chip select, active-low
- SCLK  out  1  serial clock, idle low
- COPI  out  1  serial data out

Behaviour:
- Clocking: single clock clk; rst_n asynchronous active-low. All outputs are registered.
- Reset values: nCS=1, SCLK=0, COPI=0, req_ready=1, busy=0, done=0, state=IDLE, all counters 0.
- Divider: 8-bit counter counts 0..CLK_DIV-1. It produces a `tick` on the terminal count and is cleared on every state entry.
- Frame: {req_rw, req_addr, req_data} is latched into a 16-bit shift register on the accept cycle T (req_valid & req_ready). The request inputs are ignored at all other times.
- State IDLE: req_ready=1. On accept → SETUP, and req_ready drops at T+1.
- State SETUP (CLK_DIV cycles): nCS=0, SCLK=0, COPI=frame[15]. On tick → SHIFT_HI.
- State SHIFT_HI (CLK_DIV cycles): SCLK=1; the peripheral samples COPI on this rising edge. On tick → SHIFT_LO.
- State SHIFT_LO (CLK_DIV cycles): SCLK=0.
  - On entry, if bit_cnt<15: shift left and present the next bit on COPI.
  - On tick: bit_cnt++. If bit_cnt was 15 → HOLD, else → SHIFT_HI.
- State HOLD (CLK_DIV cycles): nCS=0, SCLK=0, COPI holds the last bit. On tick → GAP.
- State GAP (CLK_DIV cycles): nCS=1, COPI=0. done=1 in the final GAP cycle, then → IDLE.
- Timing:
  - nCS is low for exactly 34*CLK_DIV cycles, T+1 .. T+34*CLK_DIV.
  - done is at cycle T+35*CLK_DIV.
  - req_ready re-asserts at T+35*CLK_DIV+1.
  - Exactly 16 rising SCLK edges per frame.
- Back-to-back: a request may be accepted in the first IDLE cycle. Minimum nCS-high gap between frames is CLK_DIV+1 cycles.
- req_valid asserted while busy: no effect, no queuing. The request is accepted only once the controller returns to IDLE.
- Reset mid-frame: nCS→1 and SCLK→0 immediately (asynchronous). The frame is abandoned and no done is issued. The peripheral discards the partial frame on nCS rising.
- busy = (state != IDLE); req_ready = ~busy.

Optional Feature:
- Macro: SPI_CONTROLLER_READ_EN.
- Defined:
  - Adds ports CIPO (in, 1) and rd_data (out, 8, reset 0).
  - For frames with req_rw=0, CIPO is sampled on the clk cycle entering each SHIFT_HI for bits 7..0 (bit_cnt 8..15), MSB first.
  - rd_data updates in the done cycle and holds until the next read frame completes.
  - Write frames leave rd_data unchanged.
- Undefined: CIPO and rd_data ports are absent. req_rw only sets frame bit 15.

Decomposition:
- Package spi_ctrl_pkg:
  - state encoding: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
  - constants: FRAME_W=16, ADDR_W=7, DATA_W=8, RW_BIT=15.
  - the register address map shared with the peripheral: 0x00 en_out_7_0, 0x01 en_out_15_8, 0x02 en_pwm_7_0, 0x03 en_pwm_15_8, 0x04 pwm_duty.
- Sub-module: spi_clk_div, the parameterised half-period tick generator with synchronous clear.
- Frame shift register and FSM stay in spi_controller.

Test Plan:
- Reset: hold rst_n=0 → nCS=1, SCLK=0, COPI=0, req_ready=1, done=0. Assert rst_n mid-cycle → outputs change without a clk edge.
- Single write, CLK_DIV=4, rw=1, addr=0x00, data=0xF0 → bench decodes 0x80F0 from 16 rising SCLK edges. nCS low 136 cycles; done at T+140; req_ready at T+141.
- Register programming: write 0x04←0x80, then 0x02←0xFF, back-to-back with req_valid held high → both frames correct. Second accept at T+141. nCS high ≥5 cycles between frames. Instantiated peripheral shows duty=0x80 and en_pwm_7_0=0xFF.
- Busy ignore: change req_addr/req_data and pulse req_valid during a frame → current frame bits unchanged; no extra frame; done pulses once.
- Reset mid-frame: assert rst_n=0 after the 7th rising SCLK → nCS=1 immediately, no done. A subsequent write 0x01←0x55 decodes correctly as 0x8155.
- (SPI_CONTROLLER_READ_EN) Read rw=0, addr=0x02, with CIPO driven as 0xA5 on bits 7..0 → frame decodes 0x0200; rd_data=0xA5 at done; a subsequent write leaves rd_data=0xA5.
